// File: rtl/psum_adder_ctrl.sv
// Sequences bias fetch into the adder bias FIFO and gates MAC psum vectors into the adder tree.
// Latency: bias push 1 cycle after bias_rd_en; psum fire is combinational (adder_i_valid == valid & ready).
// Backpressure: bias reads stall at FIFO_DEPTH credits; mac_psum_ready drops without a queued bias or during the gap.
module psum_adder_ctrl #(
    parameter int BIAS_ADDR_WIDTH = 10,
    parameter int OC_WIDTH        = 10,
    parameter int PIX_WIDTH       = 12,
    parameter int FIFO_DEPTH      = 8,
    parameter int MIN_GAP         = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [OC_WIDTH-1:0]        cfg_num_oc,
    input  logic [PIX_WIDTH-1:0]       cfg_num_pix,
    input  logic [BIAS_ADDR_WIDTH-1:0] cfg_bias_base,
    input  logic                       mac_psum_valid,
    output logic                       mac_psum_ready,
    output logic                       bias_rd_en,
    output logic [BIAS_ADDR_WIDTH-1:0] bias_rd_addr,
    input  logic [15:0]                bias_rd_data,
    output logic [15:0]                adder_bias_in,
    output logic                       adder_bias_valid,
    output logic                       adder_i_valid,
    output logic                       adder_layer_fin,
    input  logic                       adder_o_valid,
    input  logic                       adder_o_last,
    output logic                       busy,
    output logic                       done
);
    localparam int NW = OC_WIDTH + PIX_WIDTH;   // total vector count width
    localparam int CW = NW + 1;                 // running counters, one spare bit
    localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic [PIX_WIDTH-1:0]       num_pix_q, num_pix_d;
    logic [BIAS_ADDR_WIDTH-1:0] base_q, base_d;
    logic [NW-1:0]              total_q, total_d;
    logic [CW-1:0]              fetched_q, fetched_d;
    logic [CW-1:0]              pushed_q, pushed_d;
    logic [CW-1:0]              issued_q, issued_d;
    logic [CW-1:0]              retired_q, retired_d;
    logic                       inflight_q, inflight_d;
    logic [PIX_WIDTH-1:0]       pix_cnt_q, pix_cnt_d;
    logic [OC_WIDTH-1:0]        oc_cnt_q, oc_cnt_d;
    logic [GW-1:0]              gap_q, gap_d;

    logic [CW-1:0] occ;
    logic [CW-1:0] total_w;
    logic          run;
    logic          fire;

    // State and counters; reset abandons any layer in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            num_pix_q  <= '0;
            base_q     <= '0;
            total_q    <= '0;
            fetched_q  <= '0;
            pushed_q   <= '0;
            issued_q   <= '0;
            retired_q  <= '0;
            inflight_q <= 1'b0;
            pix_cnt_q  <= '0;
            oc_cnt_q   <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            num_pix_q  <= num_pix_d;
            base_q     <= base_d;
            total_q    <= total_d;
            fetched_q  <= fetched_d;
            pushed_q   <= pushed_d;
            issued_q   <= issued_d;
            retired_q  <= retired_d;
            inflight_q <= inflight_d;
            pix_cnt_q  <= pix_cnt_d;
            oc_cnt_q   <= oc_cnt_d;
            gap_q      <= gap_d;
        end
    end

    // Credit tracking, psum gating, next state and outputs.
    always_comb begin
        state_d    = state_q;
        num_pix_d  = num_pix_q;
        base_d     = base_q;
        total_d    = total_q;
        fetched_d  = fetched_q;
        pushed_d   = pushed_q;
        issued_d   = issued_q;
        retired_d  = retired_q;
        inflight_d = 1'b0;
        pix_cnt_d  = pix_cnt_q;
        oc_cnt_d   = oc_cnt_q;
        gap_d      = gap_q;

        // A read in flight already owns a FIFO slot even though it has not been pushed yet.
        occ     = pushed_q - retired_q + CW'(inflight_q);
        total_w = {1'b0, total_q};
        run     = (state_q == S_RUN);

        bias_rd_en       = run && (occ < CW'(FIFO_DEPTH)) && (fetched_q != total_w);
        bias_rd_addr     = base_q + BIAS_ADDR_WIDTH'(oc_cnt_q);
        adder_bias_valid = inflight_q;
        adder_bias_in    = inflight_q ? bias_rd_data : 16'h0000;

        // A vector may only enter once its bias has already landed in the adder FIFO.
        mac_psum_ready  = run && (pushed_q != issued_q) && (gap_q == '0) && (issued_q != total_w);
        fire            = mac_psum_valid && mac_psum_ready;
        adder_i_valid   = fire;
        adder_layer_fin = fire && (issued_q == total_w - CW'(1));

        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);

        if (bias_rd_en) begin
            fetched_d  = fetched_q + CW'(1);
            inflight_d = 1'b1;
            if (pix_cnt_q == num_pix_q - PIX_WIDTH'(1)) begin
                pix_cnt_d = '0;
                oc_cnt_d  = oc_cnt_q + OC_WIDTH'(1);
            end else begin
                pix_cnt_d = pix_cnt_q + PIX_WIDTH'(1);
            end
        end
        if (inflight_q) begin
            pushed_d = pushed_q + CW'(1);
        end
        if (adder_o_valid) begin
            retired_d = retired_q + CW'(1);
        end
        if (fire) begin
            issued_d = issued_q + CW'(1);
            gap_d    = GW'(MIN_GAP - 1);
        end else if (gap_q != '0) begin
            gap_d = gap_q - GW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_pix_d = cfg_num_pix;
                    base_d    = cfg_bias_base;
                    total_d   = NW'(cfg_num_oc) * NW'(cfg_num_pix);
                    fetched_d = '0;
                    pushed_d  = '0;
                    issued_d  = '0;
                    retired_d = '0;
                    pix_cnt_d = '0;
                    oc_cnt_d  = '0;
                    gap_d     = '0;
                    state_d   = (cfg_num_oc == '0 || cfg_num_pix == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (adder_layer_fin) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (adder_o_last) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_psum_adder_ctrl.sv
module tb_psum_adder_ctrl;
    localparam int LAT = 4;   // adder result latency in the environment model
    localparam int GAP = 3;

    logic        clk = 1'b0;
    logic        rst, start, mac_psum_valid, mac_psum_ready;
    logic [9:0]  cfg_num_oc;
    logic [11:0] cfg_num_pix;
    logic [9:0]  cfg_bias_base;
    logic        bias_rd_en;
    logic [9:0]  bias_rd_addr;
    logic [15:0] bias_rd_data, adder_bias_in;
    logic        adder_bias_valid, adder_i_valid, adder_layer_fin;
    logic        adder_o_valid, adder_o_last, busy, done;

    always #5 clk = ~clk;

    psum_adder_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_num_oc(cfg_num_oc), .cfg_num_pix(cfg_num_pix), .cfg_bias_base(cfg_bias_base),
        .mac_psum_valid(mac_psum_valid), .mac_psum_ready(mac_psum_ready),
        .bias_rd_en(bias_rd_en), .bias_rd_addr(bias_rd_addr), .bias_rd_data(bias_rd_data),
        .adder_bias_in(adder_bias_in), .adder_bias_valid(adder_bias_valid),
        .adder_i_valid(adder_i_valid), .adder_layer_fin(adder_layer_fin),
        .adder_o_valid(adder_o_valid), .adder_o_last(adder_o_last),
        .busy(busy), .done(done)
    );

    int n_vec = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] bias_of(input int a);
        int v;
        v = (a * 37 + 1445) & 16'hFFFF;
        return 16'(v) ^ 16'h8000;
    endfunction

    typedef struct {int due; bit last;} res_t;

    // Environment controls and logs (written by the env, cleared by the main sequence)
    bit   hold = 0, mac_rand = 0;
    int   addr_log[$], fire_log[$];
    int   fin_idx, done_cnt, busy_cnt, push_cnt, start_cyc;

    // Reference model state
    int          cyc = 0;
    bit          m_busy, m_done, m_prev_rd;
    int          m_prev_addr, m_base, m_pix, m_n;
    int          m_reads, m_fires, m_pushed, m_retired, m_last_fire;
    logic [15:0] bq[$];
    res_t        rq[$];

    task automatic model_clear();
        m_busy = 0; m_done = 0; m_prev_rd = 0; m_prev_addr = 0;
        m_reads = 0; m_fires = 0; m_pushed = 0; m_retired = 0; m_last_fire = -100;
        bq.delete(); rq.delete();
    endtask

    // Environment: bias BRAM, adder FIFO/result model and per-cycle compare against the spec rules
    initial begin
        bit nxt_ov, nxt_ol, nb, nd, running, exp_rd, exp_rdy, exp_fire;
        int occ;
        logic [15:0] b;
        bias_rd_data = 16'h0; adder_o_valid = 0; adder_o_last = 0; mac_psum_valid = 0;
        model_clear();
        forever begin
            @(negedge clk);
            cyc++;
            nxt_ov = 0; nxt_ol = 0;
            if (rst) begin
                model_clear();
            end else begin
                chk("busy", busy, m_busy);
                chk("done", done, m_done);
                if (done) done_cnt++;
                if (busy) busy_cnt++;
                running = m_busy && !m_done && (m_fires < m_n);
                occ = m_pushed - m_retired + int'(m_prev_rd);
                chk("occ_le_depth", occ <= 8, 1);
                exp_rd = running && (m_reads < m_n) && (occ < 8);
                chk("bias_rd_en", bias_rd_en, exp_rd);
                exp_rdy = running && (m_pushed > m_fires) && (cyc - m_last_fire >= GAP);
                chk("mac_psum_ready", mac_psum_ready, exp_rdy);
                exp_fire = mac_psum_valid && exp_rdy;
                chk("adder_i_valid", adder_i_valid, exp_fire);
                chk("adder_layer_fin", adder_layer_fin, exp_fire && (m_fires == m_n - 1));
                chk("adder_bias_valid", adder_bias_valid, m_prev_rd);
                if (bias_rd_en) addr_log.push_back(int'(bias_rd_addr));
                if (adder_layer_fin) fin_idx = m_fires;
                if (exp_fire) begin
                    if (bq.size() == 0) begin
                        chk("fire_without_bias", 0, 1);
                    end else begin
                        b = bq.pop_front();
                        chk("bias_for_vector", b, bias_of(m_base + m_fires / m_pix));
                    end
                    fire_log.push_back(cyc);
                    rq.push_back('{due: cyc + LAT, last: (m_fires == m_n - 1)});
                    m_fires++;
                    m_last_fire = cyc;
                end
                if (m_prev_rd) begin
                    chk("adder_bias_in", adder_bias_in, bias_of(m_prev_addr));
                    bq.push_back(adder_bias_in);
                    m_pushed++;
                    push_cnt++;
                end
                if (adder_o_valid) m_retired++;
                m_prev_rd = exp_rd;
                if (exp_rd) begin
                    m_prev_addr = m_base + m_reads / m_pix;
                    chk("bias_rd_addr", bias_rd_addr, m_prev_addr);
                    m_reads++;
                end
                nb = m_busy && !m_done;
                nd = 0;
                if (m_busy && adder_o_valid && adder_o_last) nd = 1;
                if (start && !m_busy) begin
                    m_base = int'(cfg_bias_base);
                    m_pix  = int'(cfg_num_pix);
                    m_n    = int'(cfg_num_oc) * int'(cfg_num_pix);
                    m_reads = 0; m_fires = 0; m_pushed = 0; m_retired = 0; m_last_fire = -100;
                    start_cyc = cyc;
                    nb = 1;
                    nd = (m_n == 0);
                end
                m_busy = nb;
                m_done = nd;
                if (!hold && rq.size() > 0 && rq[0].due <= cyc + 1) begin
                    nxt_ov = 1;
                    nxt_ol = rq[0].last;
                    void'(rq.pop_front());
                end
            end
            @(posedge clk);
            #1;
            bias_rd_data   = m_prev_rd ? bias_of(m_prev_addr) : 16'($urandom);
            adder_o_valid  = nxt_ov;
            adder_o_last   = nxt_ol;
            mac_psum_valid = mac_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic clear_logs();
        addr_log.delete(); fire_log.delete();
        fin_idx = -1; done_cnt = 0; busy_cnt = 0; push_cnt = 0;
    endtask

    task automatic do_start(input int oc, input int pix, input int base);
        @(posedge clk); #1;
        cfg_num_oc = 10'(oc); cfg_num_pix = 12'(pix); cfg_bias_base = 10'(base);
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_done(input string nm, input int max);
        int k;
        k = 0;
        while (done_cnt == 0 && k < max) begin
            @(posedge clk); #1;
            k++;
        end
        if (done_cnt == 0) chk({nm, "_timeout"}, 0, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ready"}, mac_psum_ready, 0);
        chk({nm, "_rd_en"}, bias_rd_en, 0);
        chk({nm, "_rd_addr"}, bias_rd_addr, 0);
        chk({nm, "_bias_in"}, adder_bias_in, 0);
        chk({nm, "_bias_valid"}, adder_bias_valid, 0);
        chk({nm, "_i_valid"}, adder_i_valid, 0);
        chk({nm, "_fin"}, adder_layer_fin, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
    endtask

    initial begin
        int exp2[6];
        int exp6[4];
        exp2 = '{16, 16, 16, 17, 17, 17};
        exp6 = '{32, 32, 33, 33};
        rst = 1; start = 0; cfg_num_oc = 0; cfg_num_pix = 0; cfg_bias_base = 0;
        clear_logs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        rst = 0;

        // 1: reset mid-layer abandons it
        clear_logs();
        do_start(2, 10, 5);
        repeat (15) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk_zero("midreset");
        @(posedge clk); #1;
        rst = 0;
        done_cnt = 0;
        repeat (6) @(posedge clk);
        #1;
        chk("t1_no_done", done_cnt, 0);

        // 2: oc=2 pix=3 base=0x10, fresh start after reset
        clear_logs();
        do_start(2, 3, 16);
        wait_done("t2", 200);
        chk("t2_reads", addr_log.size(), 6);
        foreach (exp2[i]) if (i < addr_log.size()) chk("t2_addr", addr_log[i], exp2[i]);
        chk("t2_fires", fire_log.size(), 6);
        chk("t2_fin_idx", fin_idx, 5);
        if (fire_log.size() > 0) chk("t2_first_fire_lat", fire_log[0] - start_cyc, 3);
        chk("t2_done_cnt", done_cnt, 1);

        // 3: credit limit with adder results held back
        clear_logs();
        hold = 1;
        do_start(1, 20, 64);
        repeat (40) @(posedge clk);
        #1;
        chk("t3_pushes_held", push_cnt, 8);
        chk("t3_reads_held", addr_log.size(), 8);
        hold = 0;
        wait_done("t3", 400);
        chk("t3_pushes_total", push_cnt, 20);
        chk("t3_fires", fire_log.size(), 20);
        chk("t3_done_cnt", done_cnt, 1);

        // 4: fire spacing with MAC always valid
        clear_logs();
        do_start(3, 4, 128);
        wait_done("t4", 300);
        chk("t4_fires", fire_log.size(), 12);
        for (int i = 1; i < fire_log.size(); i++) chk("t4_spacing", fire_log[i] - fire_log[i-1], 3);

        // 5: empty layer
        clear_logs();
        do_start(3, 0, 16);
        wait_done("t5", 20);
        chk("t5_busy_cycles", busy_cnt, 1);
        chk("t5_done_cnt", done_cnt, 1);
        chk("t5_reads", addr_log.size(), 0);
        chk("t5_fires", fire_log.size(), 0);

        // 6: start while busy is ignored (random MAC valid)
        clear_logs();
        mac_rand = 1;
        do_start(2, 2, 32);
        repeat (4) @(posedge clk);
        do_start(5, 5, 256);
        wait_done("t6", 300);
        repeat (6) @(posedge clk);
        #1;
        chk("t6_reads", addr_log.size(), 4);
        foreach (exp6[i]) if (i < addr_log.size()) chk("t6_addr", addr_log[i], exp6[i]);
        chk("t6_fires", fire_log.size(), 4);
        chk("t6_done_cnt", done_cnt, 1);
        chk("t6_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
